// File: rtl/mmio_fifo_pkg.sv
// Shared types and constants for the MMIO FIFO bridge AFU.
// Holds a minimal slice of the CCI-P channel structs, the register map and the channel status layout.
package mmio_fifo_pkg;

   typedef struct packed {
      logic [8:0]  tid;
      logic        rsvd;
      logic [1:0]  length;
      logic [15:0] address;
   } t_ccip_c0_ReqMmioHdr;

   typedef struct packed {
      t_ccip_c0_ReqMmioHdr hdr;
      logic [511:0]        data;
      logic                rspValid;
      logic                mmioRdValid;
      logic                mmioWrValid;
   } t_if_ccip_c0_Rx;

   typedef struct packed {
      logic           c0TxAlmFull;
      logic           c1TxAlmFull;
      t_if_ccip_c0_Rx c0;
   } t_if_ccip_Rx;

   typedef struct packed {
      logic [73:0] hdr;
      logic        valid;
   } t_if_ccip_c0_Tx;

   typedef struct packed {
      logic [79:0]  hdr;
      logic [511:0] data;
      logic         valid;
   } t_if_ccip_c1_Tx;

   typedef struct packed {
      logic [8:0] tid;
   } t_ccip_c2_RspMmioHdr;

   typedef struct packed {
      t_ccip_c2_RspMmioHdr hdr;
      logic                mmioRdValid;
      logic [63:0]         data;
   } t_if_ccip_c2_Tx;

   typedef struct packed {
      t_if_ccip_c0_Tx c0;
      t_if_ccip_c1_Tx c1;
      t_if_ccip_c2_Tx c2;
   } t_if_ccip_Tx;

   localparam logic [15:0] DFH_OFS    = 16'h0000;
   localparam logic [15:0] ID_L_OFS   = 16'h0002;
   localparam logic [15:0] ID_H_OFS   = 16'h0004;
   localparam logic [15:0] PARAM_OFS  = 16'h0010;
   localparam logic [1:0]  DATA_OFS   = 2'd0;
   localparam logic [1:0]  STATUS_OFS = 2'd2;
   localparam logic [15:0] CH_STRIDE  = 16'd4;

   // Feature type AFU (bits 63:60) and end-of-list (bit 40).
   localparam logic [63:0] DFH_VAL  = 64'h1000_0100_0000_0000;
   localparam logic [63:0] AFU_ID_L = 64'h9C3A_5E11_0B2D_4F70;
   localparam logic [63:0] AFU_ID_H = 64'h4D8E_1F62_A7C5_30B9;

   typedef struct packed {
      logic [31:0] count;
      logic [11:0] rsvd;
      logic        udf;
      logic        ovf;
      logic        full;
      logic        empty;
   } t_ch_status;

   function automatic logic [63:0] status_word(input t_ch_status s);
      return {16'h0000, s};
   endfunction

endpackage

// File: rtl/sync_fifo_ch.sv
// One show-ahead FIFO channel with occupancy count and sticky overflow/underflow flags.
module sync_fifo_ch #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [DATA_W-1:0]      push_data,
   input  logic                   pop,
   output logic [DATA_W-1:0]      head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty,
   output logic                   ovf,
   output logic                   udf,
   input  logic                   clr_err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wptr_q, rptr_q;
   logic [AW:0]       count_q, count_d;
   logic              ovf_q, ovf_d, udf_q, udf_d;
   logic              push_ok_s, pop_ok_s;

   assign full      = (count_q == FULL_CNT);
   assign empty     = (count_q == '0);
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;
   assign head      = mem_q[rptr_q];
   assign count     = count_q;
   assign ovf       = ovf_q;
   assign udf       = udf_q;

   // Next occupancy and sticky error flags; a clear request wins over a new error.
   always_comb begin
      count_d = count_q + {{AW{1'b0}}, push_ok_s} - {{AW{1'b0}}, pop_ok_s};
      if (clr_err) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end else begin
         ovf_d = ovf_q | (push & full);
         udf_d = udf_q | (pop & empty);
      end
   end

   // Storage is not reset; it is only observable after a push.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_q[wptr_q] <= push_data;
      end
   end

   // Pointers wrap naturally modulo DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         if (push_ok_s) wptr_q <= wptr_q + AW'(1);
         if (pop_ok_s)  rptr_q <= rptr_q + AW'(1);
         count_q <= count_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

endmodule

// File: rtl/mmio_fifo_bridge.sv
// CCI-P MMIO AFU exposing NUM_CH FIFO queues: writes to a DATA register push, reads pop.
// Decodes c0 MMIO requests, steers per-channel strobes and returns registered c2 responses.
module mmio_fifo_bridge
   import mmio_fifo_pkg::*;
#(
   parameter int          DATA_W = 64,
   parameter int          DEPTH  = 16,
   parameter int          NUM_CH = 4,
   parameter logic [15:0] BASE   = 16'h0020
) (
   input  logic        clk,
   input  logic        rst,
   input  t_if_ccip_Rx rx,
   output t_if_ccip_Tx tx
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [63:0] PARAM_VAL = {32'h0, 8'(NUM_CH), 8'(DATA_W), 16'(DEPTH)};

   logic [15:0]       addr_s, ofs_s;
   logic              rd_s, wr_s, in_range_s;
   logic [NUM_CH-1:0] push_s, pop_s, clr_s;
   logic [NUM_CH-1:0] full_s, empty_s, ovf_s, udf_s;
   logic [DATA_W-1:0] head_s  [NUM_CH];
   logic [CW-1:0]     count_s [NUM_CH];
   t_ch_status        st_s;
   logic [63:0]       rdata_d, rdata_q;
   logic              rd_valid_q;
   logic [8:0]        tid_q;

   assign addr_s     = rx.c0.hdr.address;
   assign rd_s       = rx.c0.mmioRdValid;
   // A simultaneous write is illegal on CCI-P; drop it so the read is serviced alone.
   assign wr_s       = rx.c0.mmioWrValid & ~rd_s;
   assign ofs_s      = addr_s - BASE;
   assign in_range_s = (addr_s >= BASE) && (ofs_s < (CH_STRIDE * 16'(NUM_CH)));

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      sync_fifo_ch #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ch (
         .clk       (clk),
         .rst       (rst),
         .push      (push_s[g]),
         .push_data (rx.c0.data[DATA_W-1:0]),
         .pop       (pop_s[g]),
         .head      (head_s[g]),
         .count     (count_s[g]),
         .full      (full_s[g]),
         .empty     (empty_s[g]),
         .ovf       (ovf_s[g]),
         .udf       (udf_s[g]),
         .clr_err   (clr_s[g])
      );
   end

   // Address decode into one-hot channel strobes plus the read-data mux.
   always_comb begin
      push_s  = '0;
      pop_s   = '0;
      clr_s   = '0;
      st_s    = '0;
      case (addr_s)
         DFH_OFS:   rdata_d = DFH_VAL;
         ID_L_OFS:  rdata_d = AFU_ID_L;
         ID_H_OFS:  rdata_d = AFU_ID_H;
         PARAM_OFS: rdata_d = PARAM_VAL;
         default:   rdata_d = 64'h0;
      endcase
      for (int c = 0; c < NUM_CH; c++) begin
         if (in_range_s && (ofs_s[15:2] == 14'(c))) begin
            if (ofs_s[1:0] == DATA_OFS) begin
               push_s[c] = wr_s;
               pop_s[c]  = rd_s;
               rdata_d   = empty_s[c] ? 64'h0 : 64'(head_s[c]);
            end else if (ofs_s[1:0] == STATUS_OFS) begin
               clr_s[c]   = wr_s;
               st_s.count = 32'(count_s[c]);
               st_s.udf   = udf_s[c];
               st_s.ovf   = ovf_s[c];
               st_s.full  = full_s[c];
               st_s.empty = empty_s[c];
               rdata_d    = status_word(st_s);
            end else begin
               rdata_d = 64'h0;
            end
         end else begin
            clr_s[c] = 1'b0;
         end
      end
   end

   // c2 response registers; the data reflects state sampled on the request edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         tid_q      <= 9'h0;
         rdata_q    <= 64'h0;
      end else begin
         rd_valid_q <= rd_s;
         if (rd_s) begin
            tid_q   <= rx.c0.hdr.tid;
            rdata_q <= rdata_d;
         end
      end
   end

   // c0/c1 stay idle; c2 is driven straight from the response registers.
   always_comb begin
      tx                = '0;
      tx.c2.mmioRdValid = rd_valid_q;
      tx.c2.hdr.tid     = tid_q;
      tx.c2.data        = rdata_q;
   end

endmodule

// File: tb/tb_mmio_fifo_bridge.sv
// Self-checking bench for mmio_fifo_bridge: directed scenarios plus random MMIO traffic
// compared against a queue-based model of the register map.
module tb_mmio_fifo_bridge;
   import mmio_fifo_pkg::*;

   localparam int          DATA_W = 64;
   localparam int          DEPTH  = 16;
   localparam int          NUM_CH = 4;
   localparam logic [15:0] BASE   = 16'h0020;

   localparam logic [63:0] EXP_DFH   = 64'h1000_0100_0000_0000;
   localparam logic [63:0] EXP_ID_L  = 64'h9C3A_5E11_0B2D_4F70;
   localparam logic [63:0] EXP_ID_H  = 64'h4D8E_1F62_A7C5_30B9;
   localparam logic [63:0] EXP_PARAM = {32'h0, 8'(NUM_CH), 8'(DATA_W), 16'(DEPTH)};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   t_if_ccip_Rx rx;
   t_if_ccip_Tx tx;

   int errors = 0;
   int checks = 0;

   logic [63:0] mq [NUM_CH][$];
   bit          m_ovf [NUM_CH];
   bit          m_udf [NUM_CH];

   always #5 clk = ~clk;

   mmio_fifo_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .BASE(BASE)) dut (
      .clk (clk),
      .rst (rst),
      .rx  (rx),
      .tx  (tx)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         mq[c].delete();
         m_ovf[c] = 1'b0;
         m_udf[c] = 1'b0;
      end
   endfunction

   function automatic void decode(input logic [15:0] a, output int ch, output int r);
      if (a >= BASE && a < BASE + 16'(4 * NUM_CH)) begin
         ch = int'(a - BASE) / 4;
         r  = int'(a - BASE) % 4;
      end else begin
         ch = -1;
         r  = -1;
      end
   endfunction

   function automatic logic [63:0] model_read(input logic [15:0] a);
      int ch, r;
      decode(a, ch, r);
      if (ch >= 0) begin
         if (r == 0) begin
            if (mq[ch].size() == 0) begin
               m_udf[ch] = 1'b1;
               return 64'h0;
            end
            return mq[ch].pop_front();
         end
         if (r == 2)
            return {16'h0, 32'(mq[ch].size()), 12'h0, m_udf[ch], m_ovf[ch],
                    mq[ch].size() == DEPTH, mq[ch].size() == 0};
         return 64'h0;
      end
      case (a)
         16'h0000: return EXP_DFH;
         16'h0002: return EXP_ID_L;
         16'h0004: return EXP_ID_H;
         16'h0010: return EXP_PARAM;
         default:  return 64'h0;
      endcase
   endfunction

   function automatic void model_write(input logic [15:0] a, input logic [63:0] d);
      int ch, r;
      decode(a, ch, r);
      if (ch >= 0 && r == 0) begin
         if (mq[ch].size() < DEPTH) mq[ch].push_back(d);
         else                       m_ovf[ch] = 1'b1;
      end else if (ch >= 0 && r == 2) begin
         m_ovf[ch] = 1'b0;
         m_udf[ch] = 1'b0;
      end
   endfunction

   // All op tasks start and end on a falling edge, so consecutive calls are back-to-back.
   task automatic do_write(input logic [15:0] a, input logic [63:0] d);
      model_write(a, d);
      rx.c0.hdr.address = a;
      rx.c0.data        = {448'h0, d};
      rx.c0.mmioWrValid = 1'b1;
      @(negedge clk);
      rx.c0.mmioWrValid = 1'b0;
      checks++;
      if (tx.c2.mmioRdValid !== 1'b0) begin
         errors++;
         $display("FAIL wr_no_rsp @%h: rdvalid got %b want 0", a, tx.c2.mmioRdValid);
      end
   endtask

   task automatic do_read(input logic [15:0] a, input string name);
      logic [63:0] exp;
      logic [8:0]  tid;
      exp = model_read(a);
      tid = 9'($urandom);
      rx.c0.hdr.address = a;
      rx.c0.hdr.tid     = tid;
      rx.c0.mmioRdValid = 1'b1;
      @(negedge clk);
      rx.c0.mmioRdValid = 1'b0;
      checks++;
      if (tx.c2.mmioRdValid !== 1'b1) begin
         errors++;
         $display("FAIL %s valid @%h: got %b want 1", name, a, tx.c2.mmioRdValid);
      end
      checks++;
      if (tx.c2.hdr.tid !== tid) begin
         errors++;
         $display("FAIL %s tid @%h: got %h want %h", name, a, tx.c2.hdr.tid, tid);
      end
      checks++;
      if (tx.c2.data !== exp) begin
         errors++;
         $display("FAIL %s data @%h: got %h want %h", name, a, tx.c2.data, exp);
      end
   endtask

   task automatic test_reset();
      rx  = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (tx !== '0) begin
         errors++;
         $display("FAIL reset_tx: c2 got valid=%b tid=%h data=%h want all 0",
                  tx.c2.mmioRdValid, tx.c2.hdr.tid, tx.c2.data);
      end
      rst = 1'b0;
      model_reset();
      do_read(16'h0000, "dfh");
      do_read(16'h0002, "id_l");
      do_read(16'h0004, "id_h");
      do_read(16'h0006, "zero6");
      do_read(16'h0010, "param");
      do_read(BASE + 16'd2, "status0_reset");
   endtask

   task automatic test_basic();
      do_write(BASE, 64'hA1);
      do_write(BASE, 64'hA2);
      do_write(BASE, 64'hA3);
      for (int i = 0; i < 3; i++) do_read(BASE, "basic_pop");
      do_read(BASE + 16'd2, "basic_status");
   endtask

   task automatic test_overflow();
      for (int i = 0; i <= DEPTH; i++) do_write(BASE + 16'd4, 64'(i));
      do_read(BASE + 16'd6, "ovf_status");
      for (int i = 0; i < DEPTH; i++) do_read(BASE + 16'd4, "ovf_pop");
      do_read(BASE + 16'd6, "ovf_status_drained");
      do_write(BASE + 16'd6, 64'h0);
      do_read(BASE + 16'd6, "ovf_status_clr");
   endtask

   task automatic test_underflow();
      do_read(BASE + 16'd8, "udf_pop");
      do_read(BASE + 16'd10, "udf_status");
      do_write(BASE + 16'd10, 64'h0);
      do_read(BASE + 16'd10, "udf_status_clr");
   endtask

   task automatic test_push_then_pop();
      do_write(BASE + 16'd8, 64'hDEAD_BEEF_0123_4567);
      do_read(BASE + 16'd10, "ptp_status_next");
      do_write(BASE + 16'd8, 64'hFEED_FACE_8899_AABB);
      do_read(BASE + 16'd8, "ptp_pop_next");
      do_read(BASE + 16'd8, "ptp_pop_second");
   endtask

   task automatic test_both_valid();
      logic [63:0] exp;
      do_write(BASE + 16'd8, 64'h5555);
      exp = model_read(BASE + 16'd8);
      rx.c0.hdr.address = BASE + 16'd8;
      rx.c0.hdr.tid     = 9'h1A5;
      rx.c0.data        = {448'h0, 64'h7777};
      rx.c0.mmioRdValid = 1'b1;
      rx.c0.mmioWrValid = 1'b1;
      @(negedge clk);
      rx.c0.mmioRdValid = 1'b0;
      rx.c0.mmioWrValid = 1'b0;
      checks++;
      if (tx.c2.mmioRdValid !== 1'b1 || tx.c2.data !== exp) begin
         errors++;
         $display("FAIL both_valid: got valid=%b data=%h want 1 %h", tx.c2.mmioRdValid, tx.c2.data, exp);
      end
      do_read(BASE + 16'd10, "both_status");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 20; i++) begin
         do_write(BASE, 64'h1000 + 64'(i));
         do_write(BASE + 16'd12, 64'h3000 + 64'(i));
         if (i >= 3) begin
            do_read(BASE, "wrap_ch0");
            do_read(BASE + 16'd12, "wrap_ch3");
         end
      end
      for (int i = 0; i < 3; i++) begin
         do_read(BASE, "drain_ch0");
         do_read(BASE + 16'd12, "drain_ch3");
      end
      do_read(BASE + 16'd2, "wrap_status0");
      do_read(BASE + 16'd14, "wrap_status3");
   endtask

   task automatic test_random();
      logic [15:0] misc [10];
      misc = '{16'h0000, 16'h0002, 16'h0004, 16'h0006, 16'h0008, 16'h0010,
               16'h0012, 16'h0021, 16'h0023, 16'h0030};
      for (int n = 0; n < 400; n++) begin
         int unsigned kind, ch;
         logic [15:0] a;
         kind = $urandom_range(0, 11);
         ch   = $urandom_range(0, NUM_CH - 1);
         a    = BASE + 16'(4 * ch);
         case (kind)
            0, 1, 2, 3, 4: do_write(a, {$urandom, $urandom});
            5, 6, 7:       do_read(a, "rnd_pop");
            8:             do_read(a + 16'd2, "rnd_status");
            9:             do_write(a + 16'd2, 64'(n));
            10:            do_read(misc[$urandom_range(0, 9)], "rnd_misc_rd");
            default:       do_write(misc[$urandom_range(0, 9)], {$urandom, $urandom});
         endcase
      end
      for (int c = 0; c < NUM_CH; c++) do_read(BASE + 16'(4 * c) + 16'd2, "rnd_final_status");
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 5; i++) do_write(BASE, 64'hC0 + 64'(i));
      rx.c0.hdr.address = BASE;
      rx.c0.hdr.tid     = 9'h0F0;
      rx.c0.mmioRdValid = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      rx.c0.mmioRdValid = 1'b0;
      #1;
      checks++;
      if (tx.c2.mmioRdValid !== 1'b0) begin
         errors++;
         $display("FAIL midrst_no_rsp: valid got %b want 0", tx.c2.mmioRdValid);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (tx !== '0) begin
         errors++;
         $display("FAIL midrst_tx: c2 got valid=%b data=%h want all 0", tx.c2.mmioRdValid, tx.c2.data);
      end
      rst = 1'b0;
      model_reset();
      do_read(BASE + 16'd2, "midrst_status");
      do_read(BASE, "midrst_pop_empty");
      do_read(BASE + 16'd2, "midrst_status_udf");
   endtask

   initial begin
      rx = '0;
      test_reset();
      test_basic();
      test_overflow();
      test_underflow();
      test_push_then_pop();
      test_both_valid();
      test_back_to_back();
      test_random();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
